// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared definitions for the elevator request queue and the car model:
// floor count, floor index type, direction encodings and small helpers.
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of set bits in a floor bitmap (at most NUM_FLOORS, fits in 3 bits).
  function automatic logic [2:0] floor_popcount(input logic [NUM_FLOORS-1:0] bits);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cnt = cnt + {2'b00, bits[i]};
    end
    return cnt;
  endfunction

  // One-hot mask for a floor index; all zeros when the index is past the top floor.
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input floor_t floor);
    logic [NUM_FLOORS-1:0] mask;
    mask = {NUM_FLOORS{1'b0}};
    for (int i = 0; i < NUM_FLOORS; i++) begin
      mask[i] = (floor == FLOOR_W'(i));
    end
    return mask;
  endfunction

endpackage

// File: rtl/elevator_dir_select.sv
// elevator_dir_select
// Combinational SCAN direction picker. Keeps travelling in the present
// direction while requests remain that way, turns around only when the
// other side holds requests, and otherwise holds the present direction.
// Ports:
//   pend_next        in  pending-floor bitmap to evaluate
//   current_floor    in  car's present floor (values past the top floor
//                        treat every pending floor as below)
//   current_up_ndown in  car's present direction (1 = up)
//   next_up_ndown    out recommended direction (1 = up)
module elevator_dir_select
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pend_next,
  input  floor_t                current_floor,
  input  logic                  current_up_ndown,
  output logic                  next_up_ndown
);

  logic above_s;
  logic below_s;

  // Reduce pending floors into strictly-above / strictly-below flags.
  always_comb begin
    above_s = 1'b0;
    below_s = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > current_floor) begin
        above_s = above_s | pend_next[i];
      end else if (FLOOR_W'(i) < current_floor) begin
        below_s = below_s | pend_next[i];
      end else begin
        above_s = above_s;
      end
    end
  end

  // SCAN choice: prefer the present direction, fall back to the other side.
  always_comb begin
    next_up_ndown = current_up_ndown;
    if (current_up_ndown == DIR_UP) begin
      if (above_s) begin
        next_up_ndown = DIR_UP;
      end else if (below_s) begin
        next_up_ndown = DIR_DOWN;
      end else begin
        next_up_ndown = DIR_UP;
      end
    end else begin
      if (below_s) begin
        next_up_ndown = DIR_DOWN;
      end else if (above_s) begin
        next_up_ndown = DIR_UP;
      end else begin
        next_up_ndown = DIR_DOWN;
      end
    end
  end

endmodule

// File: rtl/elevator_request_queue.sv
// elevator_request_queue
// Latches hall/car call buttons into a pending-floor bitmap, clears a floor
// when the car reports service there, and recommends the next travel
// direction with a SCAN policy. All outputs are registered from the same
// next-state bitmap so they always agree with each other.
// Ports:
//   clk              in  system clock
//   reset            in  synchronous active-high reset
//   call_btn         in  level call buttons, one per floor
//   current_floor    in  car's present floor
//   current_up_ndown in  car's present direction (1 = up)
//   deassert_floor   in  car serving current_floor (doors open)
//   queue_status     out pending-request bitmap
//   queue_empty      out 1 when no request is pending
//   next_up_ndown    out recommended direction (1 = up)
//   pending_count    out number of pending requests
module elevator_request_queue
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  floor_t                current_floor,
  input  logic                  current_up_ndown,
  input  logic                  deassert_floor,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic                  queue_empty,
  output logic                  next_up_ndown,
  output logic [2:0]            pending_count
);

  logic [NUM_FLOORS-1:0] btn_r;
  logic                  deassert_r;
  floor_t                svc_floor_r;

  logic [NUM_FLOORS-1:0] new_call_s;
  logic                  svc_s;
  logic [NUM_FLOORS-1:0] cur_mask_s;
  logic [NUM_FLOORS-1:0] clr_mask_s;
  logic [NUM_FLOORS-1:0] accepted_s;
  logic [NUM_FLOORS-1:0] pend_next_s;
  logic                  dir_next_s;

  // Edge detect, service event and next pending bitmap.
  always_comb begin
    new_call_s = call_btn & ~btn_r;
    // Service fires on doors opening, or on reaching a new floor with doors still held open.
    svc_s      = deassert_floor & (~deassert_r | (current_floor != svc_floor_r));
    // Zero for out-of-range floors, so no clear and no drop happens there.
    cur_mask_s = floor_onehot(current_floor);
    if (svc_s) begin
      clr_mask_s = cur_mask_s;
    end else begin
      clr_mask_s = {NUM_FLOORS{1'b0}};
    end
    // A call for the floor whose doors are open is already satisfied.
    if (deassert_floor) begin
      accepted_s = new_call_s & ~cur_mask_s;
    end else begin
      accepted_s = new_call_s;
    end
    pend_next_s = (queue_status | accepted_s) & ~clr_mask_s;
  end

  elevator_dir_select u_dir_select (
    .pend_next        (pend_next_s),
    .current_floor    (current_floor),
    .current_up_ndown (current_up_ndown),
    .next_up_ndown    (dir_next_s)
  );

  // Input history registers; buttons start as "held" so presses spanning reset are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_r       <= {NUM_FLOORS{1'b1}};
      deassert_r  <= 1'b0;
      svc_floor_r <= {FLOOR_W{1'b0}};
    end else begin
      btn_r      <= call_btn;
      deassert_r <= deassert_floor;
      if (deassert_floor) begin
        svc_floor_r <= current_floor;
      end else begin
        svc_floor_r <= svc_floor_r;
      end
    end
  end

  // Registered outputs, all derived from pend_next_s in the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      queue_status  <= {NUM_FLOORS{1'b0}};
      queue_empty   <= 1'b1;
      next_up_ndown <= DIR_DOWN;
      pending_count <= 3'd0;
    end else begin
      queue_status  <= pend_next_s;
      queue_empty   <= (pend_next_s == {NUM_FLOORS{1'b0}});
      next_up_ndown <= dir_next_s;
      pending_count <= floor_popcount(pend_next_s);
    end
  end

endmodule

// File: tb/tb_elevator_request_queue.sv
module tb_elevator_request_queue;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] call_btn = 7'h7F;
  logic [2:0] current_floor = 3'd0;
  logic       current_up_ndown = 1'b0;
  logic       deassert_floor = 1'b0;
  logic [6:0] queue_status;
  logic       queue_empty;
  logic       next_up_ndown;
  logic [2:0] pending_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit pend  [7];
  bit btn_h [7];
  bit m_dq;
  int m_sf;
  bit m_dir;

  elevator_request_queue dut (
    .clk              (clk),
    .reset            (reset),
    .call_btn         (call_btn),
    .current_floor    (current_floor),
    .current_up_ndown (current_up_ndown),
    .deassert_floor   (deassert_floor),
    .queue_status     (queue_status),
    .queue_empty      (queue_empty),
    .next_up_ndown    (next_up_ndown),
    .pending_count    (pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int cf;
    bit svc;
    int above;
    int below;
    cf = int'(current_floor);
    if (reset) begin
      for (int f = 0; f < 7; f++) begin
        pend[f]  = 1'b0;
        btn_h[f] = 1'b1;
      end
      m_dq  = 1'b0;
      m_sf  = 0;
      m_dir = 1'b0;
      return;
    end
    svc = deassert_floor && (!m_dq || cf != m_sf);
    for (int f = 0; f < 7; f++) begin
      bit pressed;
      pressed = call_btn[f] && !btn_h[f];
      if (svc && f == cf) pend[f] = 1'b0;
      else if (pressed && !(deassert_floor && f == cf)) pend[f] = 1'b1;
      btn_h[f] = call_btn[f];
    end
    m_dq = deassert_floor;
    if (deassert_floor) m_sf = cf;
    above = 0;
    below = 0;
    for (int f = 0; f < 7; f++) begin
      if (pend[f] && f > cf) above++;
      if (pend[f] && f < cf) below++;
    end
    if (current_up_ndown) m_dir = (above > 0) ? 1'b1 : ((below > 0) ? 1'b0 : 1'b1);
    else                  m_dir = (below > 0) ? 1'b0 : ((above > 0) ? 1'b1 : 1'b0);
  endtask

  // One clock: model, edge, then compare all outputs away from the edge.
  task automatic step(input string tag);
    logic [6:0] exp_q;
    int cnt;
    model_edge();
    @(posedge clk);
    #1;
    cnt = 0;
    for (int f = 0; f < 7; f++) begin
      exp_q[f] = pend[f];
      cnt += pend[f] ? 1 : 0;
    end
    check({tag, ".queue_status"}, 32'(queue_status), 32'(exp_q));
    check({tag, ".queue_empty"}, 32'(queue_empty), 32'(cnt == 0));
    check({tag, ".pending_count"}, 32'(pending_count), 32'(cnt));
    check({tag, ".next_up_ndown"}, 32'(next_up_ndown), 32'(m_dir));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    call_btn = 7'h00;
    deassert_floor = 1'b0;
    step("rst");
    reset = 1'b0;
    step("post_rst");
  endtask

  initial begin
    // reset with every button held
    reset = 1'b1; call_btn = 7'h7F;
    step("reset0");
    step("reset1");
    check("reset_empty", 32'(queue_empty), 32'd1);
    check("reset_status", 32'(queue_status), 32'd0);
    reset = 1'b0;
    step("held_after_reset");
    check("held_ignored", 32'(queue_status), 32'd0);
    call_btn = 7'h00;
    step("release");
    call_btn = 7'b0001000;
    step("press3");
    check("press3_status", 32'(queue_status), 32'h08);
    check("press3_count", 32'(pending_count), 32'd1);
    check("press3_empty", 32'(queue_empty), 32'd0);
    call_btn = 7'h00;
    step("rel3");

    // clear floor 3, then pending {0,5} seen from floor 2 going up
    current_floor = 3'd3; deassert_floor = 1'b1;
    step("svc3");
    deassert_floor = 1'b0;
    step("close3");
    current_floor = 3'd2; current_up_ndown = 1'b1; call_btn = 7'b0100001;
    step("press05");
    check("scan_up", 32'(next_up_ndown), 32'd1);
    call_btn = 7'h00;
    current_floor = 3'd5; deassert_floor = 1'b1;
    step("svc5");
    check("svc5_status", 32'(queue_status), 32'h01);
    check("svc5_turn", 32'(next_up_ndown), 32'd0);
    deassert_floor = 1'b0;
    step("close5");

    // held button registers once
    call_btn = 7'b0010000;
    for (int i = 0; i < 20; i++) step("hold4");
    check("hold4_count", 32'(pending_count), 32'd2);
    call_btn = 7'h00;
    current_floor = 3'd4; deassert_floor = 1'b1;
    step("svc4");
    check("svc4_clear", 32'(queue_status[4]), 32'd0);
    deassert_floor = 1'b0;
    step("close4");
    call_btn = 7'b0010000;
    step("repress4");
    check("repress4", 32'(queue_status[4]), 32'd1);
    call_btn = 7'h00;
    deassert_floor = 1'b1;
    step("svc4b");
    deassert_floor = 1'b0;
    step("close4b");

    // call at open-door floor dropped, other floor accepted
    call_btn = 7'b1010000; deassert_floor = 1'b1;
    step("svc_and_call");
    check("drop4", 32'(queue_status[4]), 32'd0);
    check("accept6", 32'(queue_status[6]), 32'd1);
    call_btn = 7'h00; deassert_floor = 1'b0;
    step("close_sc");

    // doors held open while the floor changes
    do_reset();
    call_btn = 7'b0001101;
    step("press320");
    call_btn = 7'h00;
    current_floor = 3'd3; deassert_floor = 1'b1;
    step("hold_open3");
    check("clr3", 32'(queue_status), 32'h05);
    current_floor = 3'd2;
    step("hold_open2");
    check("clr2", 32'(queue_status), 32'h01);
    deassert_floor = 1'b0;
    step("close2");

    // pending only at current floor: direction holds
    do_reset();
    current_floor = 3'd1; current_up_ndown = 1'b0; call_btn = 7'b0000010;
    step("press1");
    check("hold_down", 32'(next_up_ndown), 32'd0);
    current_up_ndown = 1'b1; call_btn = 7'h00;
    step("hold_up");
    check("hold_up", 32'(next_up_ndown), 32'd1);
    call_btn = 7'b1000000;
    step("press6");
    reset = 1'b1;
    step("mid_reset");
    check("mid_reset_status", 32'(queue_status), 32'd0);
    check("mid_reset_empty", 32'(queue_empty), 32'd1);
    reset = 1'b0; call_btn = 7'h00;
    step("mid_release");

    // out-of-range floor: everything counts as below, no clear
    current_floor = 3'd7; deassert_floor = 1'b1; call_btn = 7'b1000000;
    step("floor7");
    check("floor7_keep", 32'(queue_status), 32'h40);
    check("floor7_dir", 32'(next_up_ndown), 32'd0);
    deassert_floor = 1'b0; call_btn = 7'h00;
    step("floor7_close");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) != 0)
        call_btn = 7'($urandom) & 7'($urandom) & 7'($urandom);
      if ($urandom_range(0, 2) == 0)
        current_floor = 3'($urandom_range(0, 7));
      deassert_floor = ($urandom_range(0, 3) == 0) ? ~deassert_floor : deassert_floor;
      current_up_ndown = ($urandom_range(0, 5) == 0) ? ~current_up_ndown : current_up_ndown;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
